// File: rtl/inst_fifo.sv
// Dual-port instruction queue between fetch and decode: up to two pushes and
// two pops per cycle, single-cycle flush, full flag reserving two entries.
module inst_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push_en1,
  input  logic        push_en2,
  input  logic [31:0] push_pc1,
  input  logic [31:0] push_pc2,
  input  logic [31:0] push_inst1,
  input  logic [31:0] push_inst2,
  input  logic        pop1,
  input  logic        pop2,
  output logic        out_valid1,
  output logic        out_valid2,
  output logic [31:0] out_pc1,
  output logic [31:0] out_inst1,
  output logic [31:0] out_pc2,
  output logic [31:0] out_inst2,
  output logic        fifo_full,
  output logic        empty,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] space;
  logic [1:0]    pushes_req;
  logic [1:0]    pushes;
  logic [1:0]    pops;
  logic [63:0]   rd1;
  logic [63:0]   rd2;

  // Accepted pushes are the request clipped to free space; when space is
  // below the request (at most 2) it is itself at most 1 and fits in 2 bits.
  function automatic logic [1:0] clip_push(input logic [1:0] req, input logic [CW-1:0] free);
    if (free < CW'(req)) return free[1:0];
    return req;
  endfunction

  always_comb begin
    pushes_req = {1'b0, push_en1} + {1'b0, push_en1 & push_en2};
    pops       = {1'b0, pop1 & out_valid1} + {1'b0, pop1 & pop2 & out_valid2};
    space      = CW'(DEPTH) - count;
    pushes     = clip_push(pushes_req, space);
  end

  // Storage is data only and is never reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (pushes != 2'd0) mem[tail] <= {push_pc1, push_inst1};
      if (pushes == 2'd2) mem[tail + AW'(1)] <= {push_pc2, push_inst2};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      tail     <= tail + AW'(pushes);
      head     <= head + AW'(pops);
      count    <= count + CW'(pushes) - CW'(pops);
      overflow <= (pushes < pushes_req);
    end
  end

  always_comb begin
    rd1        = mem[head];
    rd2        = mem[head + AW'(1)];
    out_valid1 = (count != '0);
    out_valid2 = (count > CW'(1));
    out_pc1    = out_valid1 ? rd1[63:32] : 32'h0;
    out_inst1  = out_valid1 ? rd1[31:0]  : 32'h0;
    out_pc2    = out_valid2 ? rd2[63:32] : 32'h0;
    out_inst2  = out_valid2 ? rd2[31:0]  : 32'h0;
    fifo_full  = (count >= CW'(DEPTH - 2));
    empty      = (count == '0);
  end

endmodule

// File: doc/inst_fifo.md
# inst_fifo

Dual-port instruction queue between the fetch stage and decode. Fetch pushes up to two fetched instructions per cycle, tagged with their PCs. Decode sees the two oldest entries and consumes up to two per cycle. The block drives `fifo_full` back to the PC generator, which holds the fetch PC while it is high. A branch or exception `flush` empties the queue in one cycle.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 4.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `flush` input 1: discard all entries; driven by branch-taken or exception.
- `push_en1` input 1: slot-1 fetch data valid (inst_data_ok1).
- `push_en2` input 1: slot-2 fetch data valid (inst_data_ok2); ignored unless `push_en1` is high.
- `push_pc1`, `push_pc2` input 32: PCs of the pushed instructions.
- `push_inst1`, `push_inst2` input 32: pushed instruction words.
- `pop1` input 1: decode consumes the head entry.
- `pop2` input 1: decode consumes the second entry; ignored unless `pop1` is high.
- `out_valid1` output 1: head entry present (count ≥ 1).
- `out_valid2` output 1: second entry present (count ≥ 2).
- `out_pc1`, `out_inst1` output 32: head entry; 0 when `out_valid1` is low.
- `out_pc2`, `out_inst2` output 32: second entry; 0 when `out_valid2` is low.
- `fifo_full` output 1: count ≥ DEPTH−2.
- `empty` output 1: count == 0.
- `overflow` output 1: one-cycle pulse when a push was dropped for lack of space.

## Operation
- State:
  - Storage holds DEPTH × {pc[31:0], inst[31:0]}.
  - Pointers `head` and `tail` are log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is log2(DEPTH)+1 bits.
- Reset, synchronous:
  - head = tail = count = 0 and overflow = 0.
  - Outputs after reset: out_valid1/2 = 0, out_* = 0, fifo_full = 0, empty = 1.
  - Storage contents are not reset.
- Flush, priority over push and pop:
  - head = tail = count = 0.
  - Pushes and pops in the same cycle are ignored; no overflow pulse.
- Requested pushes:
  - pushes_req = push_en1 + (push_en1 & push_en2).
- Requested pops, clipped to what is valid:
  - pops = pop1 & out_valid1, plus pop1 & pop2 & out_valid2.
  - A pop on an invalid slot has no effect.
- Accepted pushes:
  - pushes = min(pushes_req, DEPTH − count), where count is the registered value.
  - Same-cycle pops do not free space for same-cycle pushes.
- Write order:
  - Slot 1 is written at tail; slot 2 at tail+1 (mod DEPTH).
  - If only one push is accepted, slot 1 is kept and slot 2 is dropped.
- Pointer and count update:
  - tail += pushes.
  - head += pops.
  - count_next = count + pushes − pops.
- overflow_next = (pushes < pushes_req) & ~flush.
- Read port:
  - Combinational from storage[head] and storage[head+1], gated by the valid bits.
- `fifo_full` and `empty` decode combinationally from the registered count.
  - Reserving two entries guarantees one in-flight double push is absorbed after `fifo_full` rises.
- Order is strict FIFO; entries are never reordered or duplicated.

## Timing
- Push-to-visible latency is 1 cycle. An entry written at edge N appears on out_* after edge N; there is no same-cycle bypass.
- A pop takes effect at the next edge. The next entries appear on out_* in the same cycle head updates.
- `fifo_full` follows count with no extra delay. Fetch sees it in the same cycle and its PC holds at the next edge.
- Flush asserted in cycle N: out_valid1/2 = 0 and empty = 1 from cycle N+1. Pushes in cycle N+1 are accepted normally.
- Wrap-around: with tail = DEPTH−1 and a double push, slot 1 goes to entry DEPTH−1 and slot 2 to entry 0. Two-entry reads at head = DEPTH−1 wrap the same way.
- Simultaneous push and pop with count = DEPTH is allowed. Pushes are rejected (overflow pulses) and pops proceed.
- Rst during any operation overrides flush, push and pop.

## Test plan
1. **Reset then single pushes.**
   - Stimulus: rst, then push pc 0xbfc00000, then push pc 0xbfc00004.
   - Response: out_valid1 = 1 with out_pc1 = 0xbfc00000 one cycle after the first push; out_pc2 = 0xbfc00004 one cycle after the second; empty falls with the first push.
2. **Dual push, dual pop, with wrap.**
   - Stimulus: double-push 8 times with DEPTH = 16, popping two per cycle from the second cycle on, so pointers wrap.
   - Response: PCs are output in strictly increasing order by 4; count never exceeds 2; no overflow.
3. **Fill to full.**
   - Stimulus: double-push with no pops.
   - Response: fifo_full rises when count = 14. A further double push gives count = 16. One more push gives overflow = 1 for one cycle, count stays 16, and the head entry is unchanged.
4. **Flush with concurrent traffic.**
   - Stimulus: count = 5; assert flush together with a double push and pop1/pop2.
   - Response: next cycle count = 0, empty = 1, out_valid1 = 0, overflow = 0. A subsequent push of pc 0x80000100 appears at out_pc1.
5. **Illegal or clipped requests.**
   - Stimulus: pop2 without pop1; push_en2 without push_en1; pop1 and pop2 with count = 1.
   - Response: no state change for the first two; count goes to 0 and head advances by exactly 1 for the third.
6. **Reset mid-stream.**
   - Stimulus: assert rst with count = 9 and a push pending.
   - Response: all outputs return to reset values; the pending push is not stored.
